// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding encodings, hazard FSM states and
// the hardwired-zero register index.
package pipeline_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/forward_select.sv
// Priority comparator for one ALU operand: the youngest in-flight producer
// (EX/MEM) wins over WB, and r0 never forwards because it is always zero.
module forward_select
  import pipeline_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       use_src,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_wen,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_wen,
  output logic [1:0] fwd_sel
);

  // Select the operand source, EX/MEM first, then WB, else register file.
  always_comb begin
    fwd_sel = FWD_REG;
    if (use_src && (rs != REG_ZERO) && mem_reg_wen && (mem_rd == rs)) begin
      fwd_sel = FWD_EXMEM;
    end else if (use_src && (rs != REG_ZERO) && wb_reg_wen && (wb_rd == rs)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall detection, operand forwarding
// selects, redirect flush/refill sequencing and a saturating stall counter.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic [4:0]       id_rs_top,
  input  logic             id_use_top,
  input  logic [4:0]       id_rs_bot,
  input  logic             id_use_bot,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wen,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_wen,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_wen,
  input  logic             mem_redirect,
  output logic             stall,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             ex_mem_flush,
  output logic             pc_load,
  output logic [1:0]       fwd_top_sel,
  output logic [1:0]       fwd_bot_sel,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0]       REDIR_LOAD = 4'(REDIRECT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  hazard_state_t state_r;
  hazard_state_t next_state_s;
  logic [3:0]    cnt_r;
  logic          load_use_s;
  logic [1:0]    fwd_top_raw_s;
  logic [1:0]    fwd_bot_raw_s;

  forward_select u_fwd_top (
    .rs          (id_rs_top),
    .use_src     (id_use_top),
    .mem_rd      (mem_rd),
    .mem_reg_wen (mem_reg_wen),
    .wb_rd       (wb_rd),
    .wb_reg_wen  (wb_reg_wen),
    .fwd_sel     (fwd_top_raw_s)
  );

  forward_select u_fwd_bot (
    .rs          (id_rs_bot),
    .use_src     (id_use_bot),
    .mem_rd      (mem_rd),
    .mem_reg_wen (mem_reg_wen),
    .wb_rd       (wb_rd),
    .wb_reg_wen  (wb_reg_wen),
    .fwd_sel     (fwd_bot_raw_s)
  );

  // A load in EX whose destination feeds a used ID operand must wait one cycle.
  always_comb begin
    load_use_s = ex_mem_read && ex_reg_wen && (ex_rd != REG_ZERO) &&
                 ((id_use_top && (id_rs_top == ex_rd)) ||
                  (id_use_bot && (id_rs_bot == ex_rd)));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Refill countdown: loaded on redirect entry, decremented while flushing.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_redirect) begin
            cnt_r <= REDIR_LOAD;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_REDIRECT: cnt_r <= cnt_r - 4'd1;
        default:     cnt_r <= 4'd0;
      endcase
    end
  end

  // Next-state logic; leaving REDIRECT also on cnt 0 keeps a corrupted count from locking up.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mem_redirect) begin
          next_state_s = ST_REDIRECT;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (cnt_r <= 4'd1) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_REDIRECT;
        end
      end
      default: next_state_s = ST_RUN;
    endcase
  end

  // Control outputs; redirect beats load-use, and reset forces everything low.
  always_comb begin
    stall        = 1'b0;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_load      = 1'b0;
    fwd_top_sel  = FWD_REG;
    fwd_bot_sel  = FWD_REG;
    if (nreset) begin
      fwd_top_sel = fwd_top_raw_s;
      fwd_bot_sel = fwd_bot_raw_s;
      case (state_r)
        ST_RUN: begin
          if (mem_redirect) begin
            pc_load      = 1'b1;
            if_id_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            stall        = 1'b1;
          end else if (load_use_s) begin
            stall      = 1'b1;
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
          end else begin
            stall = 1'b0;
          end
        end
        ST_REDIRECT: begin
          if_id_flush = 1'b1;
          stall       = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end else begin
      stall = 1'b0;
    end
  end

  // Saturating count of bubble cycles for performance measurement.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_W'(1);
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_hazard_unit;

  localparam int RC = 1;
  localparam int CW = 4;
  localparam int SC_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          nreset;
  logic [4:0]    id_rs_top, id_rs_bot, ex_rd, mem_rd, wb_rd;
  logic          id_use_top, id_use_bot, ex_reg_wen, ex_mem_read;
  logic          mem_reg_wen, wb_reg_wen, mem_redirect;
  logic          stall, pc_hold, if_id_hold, if_id_flush, ex_mem_flush, pc_load;
  logic [1:0]    fwd_top_sel, fwd_bot_sel;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: remaining flush cycles after a redirect, and the stall tally.
  int redir_left = 0;
  int sc_model   = 0;

  always #5 clock = ~clock;

  hazard_unit #(.REDIRECT_CYCLES(RC), .CNT_W(CW)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .id_rs_top    (id_rs_top),
    .id_use_top   (id_use_top),
    .id_rs_bot    (id_rs_bot),
    .id_use_bot   (id_use_bot),
    .ex_rd        (ex_rd),
    .ex_reg_wen   (ex_reg_wen),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .mem_reg_wen  (mem_reg_wen),
    .wb_rd        (wb_rd),
    .wb_reg_wen   (wb_reg_wen),
    .mem_redirect (mem_redirect),
    .stall        (stall),
    .pc_hold      (pc_hold),
    .if_id_hold   (if_id_hold),
    .if_id_flush  (if_id_flush),
    .ex_mem_flush (ex_mem_flush),
    .pc_load      (pc_load),
    .fwd_top_sel  (fwd_top_sel),
    .fwd_bot_sel  (fwd_bot_sel),
    .stall_count  (stall_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic u);
    if (!u || rs == 5'd0) return 2'd0;
    if (mem_reg_wen && mem_rd == rs) return 2'd1;
    if (wb_reg_wen && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    nreset = 1'b1;
    id_rs_top = 5'd0; id_use_top = 1'b0; id_rs_bot = 5'd0; id_use_bot = 1'b0;
    ex_rd = 5'd0; ex_reg_wen = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_wen = 1'b0; wb_rd = 5'd0; wb_reg_wen = 1'b0;
    mem_redirect = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd7;
    id_rs_bot = 5'd7; id_use_bot = 1'b1;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic lu;
    logic e_stall, e_pch, e_ifh, e_iff, e_emf, e_pcl;
    logic [1:0] e_ft, e_fb;
    #4;
    lu = ex_mem_read && ex_reg_wen && ex_rd != 5'd0 &&
         ((id_use_top && id_rs_top == ex_rd) || (id_use_bot && id_rs_bot == ex_rd));
    {e_stall, e_pch, e_ifh, e_iff, e_emf, e_pcl} = 6'b0;
    e_ft = 2'd0; e_fb = 2'd0;
    if (nreset) begin
      e_ft = fwd_ref(id_rs_top, id_use_top);
      e_fb = fwd_ref(id_rs_bot, id_use_bot);
      if (redir_left > 0) begin
        e_iff = 1'b1; e_stall = 1'b1;
      end else if (mem_redirect) begin
        e_pcl = 1'b1; e_iff = 1'b1; e_emf = 1'b1; e_stall = 1'b1;
      end else if (lu) begin
        e_stall = 1'b1; e_pch = 1'b1; e_ifh = 1'b1;
      end
    end
    check_eq("stall",        stall,        e_stall);
    check_eq("pc_hold",      pc_hold,      e_pch);
    check_eq("if_id_hold",   if_id_hold,   e_ifh);
    check_eq("if_id_flush",  if_id_flush,  e_iff);
    check_eq("ex_mem_flush", ex_mem_flush, e_emf);
    check_eq("pc_load",      pc_load,      e_pcl);
    check_eq("fwd_top_sel",  fwd_top_sel,  e_ft);
    check_eq("fwd_bot_sel",  fwd_bot_sel,  e_fb);
    check_eq("stall_count",  stall_count,  sc_model);
    @(posedge clock);
    if (!nreset) begin
      redir_left = 0;
      sc_model   = 0;
    end else begin
      if (e_stall && sc_model < SC_MAX) sc_model++;
      if (redir_left > 0) redir_left--;
      else if (mem_redirect) redir_left = RC;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    nreset = 1'b0;
    @(posedge clock);
    #1;
    step();                       // reset state
    nreset = 1'b1;

    // Forwarding priority: EX/MEM over WB, then WB alone.
    mem_reg_wen = 1'b1; mem_rd = 5'd3; wb_reg_wen = 1'b1; wb_rd = 5'd3;
    id_rs_top = 5'd3; id_use_top = 1'b1;
    step();
    check_eq("tp_fwd_exmem", fwd_top_sel, 2'b01);
    mem_reg_wen = 1'b0;
    step();
    check_eq("tp_fwd_wb", fwd_top_sel, 2'b10);

    // Load-use stall, then the same with r0 as destination.
    clear_inputs();
    set_load_use();
    step();
    check_eq("tp_loaduse_cnt", stall_count, 1);
    ex_rd = 5'd0; id_rs_bot = 5'd0;
    step();
    check_eq("tp_r0_nostall", stall, 1'b0);

    // Redirect pulse: two stall cycles, then idle.
    clear_inputs();
    mem_redirect = 1'b1;
    step();
    mem_redirect = 1'b0;
    step();
    step();
    check_eq("tp_redir_cnt", stall_count, 3);

    // Redirect and load-use together; load-use ignored during REDIRECT.
    set_load_use();
    mem_redirect = 1'b1;
    step();
    mem_redirect = 1'b0;
    step();
    clear_inputs();
    step();

    // Reset asserted in the REDIRECT cycle.
    mem_redirect = 1'b1;
    step();
    mem_redirect = 1'b0;
    nreset = 1'b0;
    step();
    check_eq("tp_reset_cnt", stall_count, 0);
    nreset = 1'b1;
    step();

    // Saturation of the stall counter.
    set_load_use();
    for (int i = 0; i < (1 << CW) + 3; i++) step();
    check_eq("tp_saturate", stall_count, SC_MAX);
    clear_inputs();
    step();

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      nreset       = ($urandom_range(0, 99) >= 3);
      id_rs_top    = 5'($urandom_range(0, 3));
      id_rs_bot    = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      wb_rd        = 5'($urandom_range(0, 3));
      id_use_top   = 1'($urandom_range(0, 1));
      id_use_bot   = 1'($urandom_range(0, 1));
      ex_reg_wen   = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      mem_reg_wen  = 1'($urandom_range(0, 1));
      wb_reg_wen   = 1'($urandom_range(0, 1));
      mem_redirect = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
